// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: owns HI/LO and models a fixed-latency
// mult/div unit, stalling the pipeline while an operation is in flight.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] SrcA_E,
    input  logic [31:0] SrcB_E,
    output logic        busy,
    output logic        MD_Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div
        $error("md_sequencer: DIV_CYCLES must be within 1..15");
    end

    if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_mult
        $error("md_sequencer: MULT_CYCLES must be within 1..15");
    end

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Result datapath, driven only from the latched operands
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        quo_neg;
    logic        rem_neg;
    logic        is_div;
    logic        div_by_zero;

    always_comb begin
        prod_s = $signed({{32{a_q[31]}}, a_q})
               * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'd0, a_q} * {32'd0, b_q};
    end

    // Signed divide runs on magnitudes, then signs are restored:
    // this also yields 0x80000000 / -1 = 0x80000000 rem 0.
    always_comb begin
        div_signed  = (op_q == OP_DIV[1:0]);
        is_div      = op_q[1];
        div_by_zero = (b_q == 32'd0);
        div_a       = a_q;
        div_b       = b_q;
        if (div_signed && a_q[31]) begin
            div_a = ~a_q + 32'd1;
        end
        if (div_signed && b_q[31]) begin
            div_b = ~b_q + 32'd1;
        end
        if (div_by_zero) begin
            div_b = 32'd1;
        end
        quo_u   = div_a / div_b;
        rem_u   = div_a % div_b;
        quo_neg = div_signed && (a_q[31] ^ b_q[31]);
        rem_neg = div_signed && a_q[31];
        quo     = quo_neg ? (~quo_u + 32'd1) : quo_u;
        rem     = rem_neg ? (~rem_u + 32'd1) : rem_u;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    unique case (MDOp)
                        OP_MULT, OP_MULTU: begin
                            a_d     = SrcA_E;
                            b_d     = SrcB_E;
                            op_d    = MDOp[1:0];
                            cnt_d   = MULT_LOAD;
                            state_d = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            a_d     = SrcA_E;
                            b_d     = SrcB_E;
                            op_d    = MDOp[1:0];
                            cnt_d   = DIV_LOAD;
                            state_d = S_RUN;
                        end
                        OP_MTHI: begin
                            hi_d = SrcA_E;
                        end
                        OP_MTLO: begin
                            lo_d = SrcA_E;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    if (!is_div) begin
                        if (op_q == OP_MULT[1:0]) begin
                            {hi_d, lo_d} = prod_s;
                        end else begin
                            {hi_d, lo_d} = prod_u;
                        end
                    end else if (!div_by_zero) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign MD_Stall = ~reset & (busy | (start & ~MDOp[2]));
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 SHALL have the parameter MULT_CYCLES, default 5, giving the busy cycles for a mult/multu.
REQ-002 SHALL have the parameter DIV_CYCLES, default 10, giving the busy cycles for a div/divu; legal range 1..15, checked by assertion.
REQ-003 SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have the port start, input, 1 bit: the execute-stage instruction is an MD operation this cycle.
REQ-006 SHALL have the port MDOp, input, 3 bits: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 are reserved and treated as no-op.
REQ-007 SHALL have the ports SrcA_E and SrcB_E, input, 32 bits each: the forwarded rs and rt operands from the execute stage.
REQ-008 SHALL have the port busy, output, 1 bit: an operation is in progress.
REQ-009 SHALL have the port MD_Stall, output, 1 bit: a combinational stall request to the hazard unit.
REQ-010 SHALL have the ports HI and LO, output, 32 bits each: the architectural HI and LO registers.

Function
REQ-011 SHALL implement two states: IDLE (busy=0) and RUN (busy=1), with a 4-bit down-counter cnt.
REQ-012 SHALL, in IDLE with start=1 and MDOp 0-3, latch SrcA_E and SrcB_E and MDOp, load cnt with MULT_CYCLES (MDOp 0-1) or DIV_CYCLES (MDOp 2-3), and enter RUN on the next edge.
REQ-013 SHALL, in RUN, decrement cnt on every edge; on the edge where cnt==1 it SHALL write HI/LO from the latched operands and return to IDLE.
REQ-014 SHALL therefore keep busy high for exactly MULT_CYCLES or DIV_CYCLES cycles, starting the cycle after start.
REQ-015 SHALL make the new HI/LO values visible in the first cycle busy is low.
REQ-016 SHALL compute mult as the signed 64-bit product {HI,LO}, and multu as the unsigned 64-bit product.
REQ-017 SHALL compute div as LO = quotient truncated toward zero and HI = remainder with the sign of the dividend; divu SHALL compute the unsigned quotient and remainder.
REQ-018 SHALL handle div 0x80000000 / 0xFFFFFFFF as LO=0x80000000, HI=0.
REQ-019 SHALL, for a divisor of 0 (div or divu), still run DIV_CYCLES cycles and leave HI and LO unchanged.
REQ-020 SHALL, in IDLE with start=1 and MDOp=4, write HI=SrcA_E on that edge without entering RUN.
REQ-021 SHALL, in IDLE with start=1 and MDOp=5, write LO=SrcA_E on that edge without entering RUN.
REQ-022 SHALL ignore start in RUN: no relatch, no counter reload, no mthi/mtlo write; the hazard unit holds the instruction via MD_Stall.
REQ-023 SHALL drive MD_Stall = busy | (start & MDOp in 0-3), so the issuing cycle and every RUN cycle are stalled.
REQ-024 SHALL treat MDOp 6-7 with start=1 as a no-op, leaving state, HI and LO unchanged.
REQ-025 SHALL compute results only from the latched operands, so operand changes on SrcA_E or SrcB_E during RUN have no effect.
REQ-026 SHALL, on the completion edge (cnt==1) with start=1, finish the current operation only; a new start is accepted no earlier than the following IDLE cycle.

Reset
REQ-027 SHALL, with reset=1 at an edge, force state=IDLE, cnt=0, HI=0, LO=0, busy=0, and clear the latched operands.
REQ-028 SHALL give reset priority over start and over any in-flight completion: an operation interrupted mid-RUN SHALL never write HI/LO.
REQ-029 SHALL drive MD_Stall=0 while reset=1, regardless of start.

Verification
REQ-030 SHALL cover mult: start, MDOp=0, A=0xFFFFFFFE (-2), B=3 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 SHALL cover multu: start, MDOp=1, A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-032 SHALL cover div: start, MDOp=2, A=-7, B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); MD_Stall high for 11 cycles including the issue cycle.
REQ-033 SHALL cover divide by zero: preload HI=0x11 and LO=0x22 via mthi/mtlo, then divu with B=0 -> busy for 10 cycles, after which HI=0x11 and LO=0x22.
REQ-034 SHALL cover reset mid-operation: start mult, assert reset on RUN cycle 3 -> next cycle busy=0, HI=0, LO=0, and no later write occurs.
REQ-035 SHALL cover back-to-back operations: mtlo 0x5 during RUN is ignored; re-issued after busy falls -> LO=0x5 one edge later, with no RUN entry.
